accsum_bank: RTL and testbench

Multi-lane partial-sum accumulation buffer for the cnna convolution datapath. Each valid beat from the MAC array adds C_LANES signed partial sums into a per-address accumulator held in an internal simple-dual-port RAM, overwrites on the first input-channel pass, and serves the finished sums through a post-processed read port. It is the parametrised successor of the single-lane accumulator. It adds lanes, signed saturating arithmetic, programmable pass length with wrap, in-flight forwarding, and ReLU readout.

---
 rtl/cnna_acc_pkg.sv | 46 ++++
 rtl/sdpram.sv | 36 +++
 rtl/accsum_bank.sv | 201 ++++++++++++++++++++
 tb/tb_accsum_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnna_acc_pkg.sv
// Shared helpers for the cnna accumulation datapath: lane slicing,
// sign extension and saturation on a wide signed working type, so that
// per-lane arithmetic can be written once for any lane/data width.
package cnna_acc_pkg;

  // Beat-to-commit latency of the accumulate pipeline (stages s1..s3).
  localparam int ACC_LAT = 3;

  // Working width for lane arithmetic; every lane width must stay below it.
  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // LSB position of lane k in a lane-packed bus of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

  // Reinterpret the low w bits of v as a signed w-bit value.
  function automatic wide_t sext(input wide_t v, input int w);
    return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
  endfunction

  // Largest value representable in a signed w-bit lane.
  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  // Smallest value representable in a signed w-bit lane.
  function automatic wide_t sat_min(input int w);
    return -sat_max(w) - wide_t'(1);
  endfunction

  // True when v does not fit in a signed w-bit lane.
  function automatic logic sat_ovf(input wide_t v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

  // Bring v into signed w-bit range: clip when sat is set, otherwise wrap.
  function automatic wide_t sat_clip(input wide_t v, input int w, input logic sat);
    if (!sat_ovf(v, w)) return v;
    if (sat) return (v > sat_max(w)) ? sat_max(w) : sat_min(w);
    return sext(v, w);
  endfunction

endpackage

// File: rtl/sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Read-first on a same-address collision (the read returns the old word).
module sdpram #(
  parameter string MEM_STYLE  = "block",
  parameter int    WIDTH      = 96,
  parameter int    DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  if (MEM_STYLE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Write port and registered read port.
    // NOTE: no reset here -- a reset would stop the array mapping onto RAM
    // primitives, and the contents are treated as undefined after reset.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/accsum_bank.sv
// Multi-lane partial-sum accumulation buffer. Each accepted beat adds
// C_LANES signed inputs into the word at the current beat address
// (or overwrites it on the first pass), via a 3-stage read/add/write
// pipeline with forwarding. A separate readout port serves finished sums
// with optional ReLU.
module accsum_bank
  import cnna_acc_pkg::*;
#(
  parameter string C_MEM_STYLE = "block",
  parameter int    C_LANES     = 4,
  parameter int    C_ISIZE     = 12,
  parameter int    C_DSIZE     = 24,
  parameter int    C_ASIZE     = 10,
  parameter int    C_SAT       = 1
) (
  input  logic                       I_clk,
  input  logic                       I_rst_n,
  input  logic                       I_dven,
  input  logic [C_ASIZE:0]           I_len,
  input  logic                       I_first_flag,
  input  logic                       I_dv,
  input  logic [C_LANES*C_ISIZE-1:0] I_din,
  input  logic                       I_rd,
  input  logic [C_ASIZE-1:0]         I_raddr,
  input  logic                       I_relu,
  output logic [C_LANES*C_DSIZE-1:0] O_rdata,
  output logic                       O_rvalid,
  output logic                       O_busy,
  output logic                       O_ovf
);

  localparam int DW = C_LANES * C_DSIZE;
  localparam int IW = C_LANES * C_ISIZE;
  localparam int LW = C_ASIZE + 1;

  // ---------------------------------------------------------------------
  // Mode tracking and beat address counter
  // ---------------------------------------------------------------------
  logic               dven_q;
  logic [LW-1:0]      len_q;
  logic [C_ASIZE-1:0] rcnt;
  logic               dven_rise;
  logic [LW-1:0]      eff_len;
  logic               rcnt_wrap;
  logic               beat;

  assign beat      = I_dven & I_dv;
  assign dven_rise = I_dven & ~dven_q;
  // The length is latched on the rising edge, but a beat arriving in that
  // same cycle must already wrap against the new length.
  assign eff_len   = dven_rise ? I_len : len_q;
  assign rcnt_wrap = ({1'b0, rcnt} == (eff_len - LW'(1)));

  // Rising-edge detect, pass-length capture and beat address counter.
  // NOTE: state is updated with <= so every register samples pre-edge
  // values; blocking assignments here would create ordering races.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dven_q <= 1'b0;
      len_q  <= '0;
      rcnt   <= '0;
    end else begin
      dven_q <= I_dven;
      if (dven_rise) len_q <= I_len;
      if (!I_dven)   rcnt  <= '0;
      else if (I_dv) rcnt  <= rcnt_wrap ? '0 : rcnt + C_ASIZE'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Accumulate pipeline: s1 = RAM read in flight, s2 = old value held,
  // s3 = sum just committed (kept for forwarding past the read-first RAM)
  // ---------------------------------------------------------------------
  logic [ACC_LAT-1:0] pv;
  logic [C_ASIZE-1:0] a1, a2, a3;
  logic               f1, f2;
  logic [IW-1:0]      din1, din2;
  logic [DW-1:0]      old2, sum3;
  logic [DW-1:0]      sum_bus;
  logic [DW-1:0]      fwd;
  logic [DW-1:0]      ram_rdata;
  logic [C_ASIZE-1:0] ram_raddr;
  logic [C_LANES-1:0] lane_ovf;

  // In accumulate mode the RAM is read at the beat address, otherwise at
  // the readout address.
  assign ram_raddr = I_dven ? rcnt : I_raddr;

  // Old-value select: the youngest in-flight sum to the same address wins
  // over RAM data. s2's sum is written on the coming edge and s3's was
  // written on the edge the RAM read sampled, so RAM misses both.
  // NOTE: fwd gets a default before the overrides so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd = ram_rdata;
    if (pv[2] && (a3 == a1)) fwd = sum3;
    if (pv[1] && (a2 == a1)) fwd = sum_bus;
  end

  // Pipeline registers: beat fields travel with their valid bit so that
  // I_dv gaps never misalign address, first flag and data.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pv   <= '0;
      a1   <= '0;
      a2   <= '0;
      a3   <= '0;
      f1   <= 1'b0;
      f2   <= 1'b0;
      din1 <= '0;
      din2 <= '0;
      old2 <= '0;
      sum3 <= '0;
    end else begin
      pv   <= {pv[ACC_LAT-2:0], beat};
      a1   <= rcnt;
      f1   <= I_first_flag;
      din1 <= I_din;
      a2   <= a1;
      f2   <= f1;
      din2 <= din1;
      old2 <= fwd;
      a3   <= a2;
      sum3 <= sum_bus;
    end
  end

  // Per-lane add and saturate/wrap, plus readout ReLU.
  logic [DW-1:0] relu_bus;
  logic          relu_q;

  for (genvar k = 0; k < C_LANES; k++) begin : g_lane
    localparam int LSB_I = lane_lsb(k, C_ISIZE);
    localparam int LSB_D = lane_lsb(k, C_DSIZE);

    logic [C_ISIZE-1:0] in_lane;
    logic [C_DSIZE-1:0] old_lane;
    logic [C_DSIZE-1:0] rd_lane;
    wide_t              old_w;
    wide_t              in_w;
    wide_t              sum_w;

    assign in_lane  = din2[LSB_I +: C_ISIZE];
    assign old_lane = old2[LSB_D +: C_DSIZE];
    assign rd_lane  = ram_rdata[LSB_D +: C_DSIZE];

    assign in_w  = sext(wide_t'({{(WIDE_W-C_ISIZE){1'b0}}, in_lane}), C_ISIZE);
    assign old_w = f2 ? '0 : sext(wide_t'({{(WIDE_W-C_DSIZE){1'b0}}, old_lane}), C_DSIZE);
    assign sum_w = old_w + in_w;

    assign lane_ovf[k]               = sat_ovf(sum_w, C_DSIZE);
    assign sum_bus[LSB_D +: C_DSIZE] = C_DSIZE'(sat_clip(sum_w, C_DSIZE, C_SAT != 0));
    assign relu_bus[LSB_D +: C_DSIZE] = (relu_q && rd_lane[C_DSIZE-1]) ? '0 : rd_lane;
  end

  sdpram #(
    .MEM_STYLE  (C_MEM_STYLE),
    .WIDTH      (DW),
    .DEPTH_LOG2 (C_ASIZE)
  ) u_ram (
    .clk   (I_clk),
    .we    (pv[1]),
    .waddr (a2),
    .wdata (sum_bus),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign O_busy = |pv;

  // Sticky overflow flag, cleared when a new accumulate session starts.
  // A clip in the same cycle as the clear still sets it.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) O_ovf <= 1'b0;
    else          O_ovf <= (O_ovf & ~dven_rise) | (pv[1] & (|lane_ovf));
  end

  // ---------------------------------------------------------------------
  // Readout: request accepted only when idle, data two cycles later
  // ---------------------------------------------------------------------
  logic rd_ok;
  logic rd_q;

  assign rd_ok = I_rd & ~I_dven & ~O_busy;

  // Request tracking across the RAM latency and output register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_q     <= 1'b0;
      relu_q   <= 1'b0;
      O_rvalid <= 1'b0;
      O_rdata  <= '0;
    end else begin
      rd_q     <= rd_ok;
      relu_q   <= I_relu;
      O_rvalid <= rd_q;
      if (rd_q) O_rdata <= relu_bus;
    end
  end

endmodule

// File: tb/tb_accsum_bank.sv
// Self-checking bench for accsum_bank. Two instances share all inputs:
// one saturating, one wrapping. A lane-array reference model tracks the
// expected contents of every address for both.
module tb_accsum_bank;

  localparam int     L     = 4;
  localparam int     IS    = 12;
  localparam int     DS    = 24;
  localparam int     AS    = 10;
  localparam longint MAXV  = 8388607;
  localparam longint MINV  = -8388608;
  localparam longint SPAN  = 16777216;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dven;
  logic [AS:0]       len;
  logic              first_flag;
  logic              dv;
  logic [L*IS-1:0]   din;
  logic              rd;
  logic [AS-1:0]     raddr;
  logic              relu;

  logic [L*DS-1:0]   rdata_s, rdata_w;
  logic              rvalid_s, rvalid_w;
  logic              busy_s, busy_w;
  logic              ovf_s, ovf_w;

  always #5 clk = ~clk;

  accsum_bank #(.C_SAT(1)) dut_sat (
    .I_clk(clk), .I_rst_n(rst_n), .I_dven(dven), .I_len(len),
    .I_first_flag(first_flag), .I_dv(dv), .I_din(din), .I_rd(rd),
    .I_raddr(raddr), .I_relu(relu), .O_rdata(rdata_s), .O_rvalid(rvalid_s),
    .O_busy(busy_s), .O_ovf(ovf_s)
  );

  accsum_bank #(.C_SAT(0)) dut_wrap (
    .I_clk(clk), .I_rst_n(rst_n), .I_dven(dven), .I_len(len),
    .I_first_flag(first_flag), .I_dv(dv), .I_din(din), .I_rd(rd),
    .I_raddr(raddr), .I_relu(relu), .O_rdata(rdata_w), .O_rvalid(rvalid_w),
    .O_busy(busy_w), .O_ovf(ovf_w)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-address lane values for both arithmetic modes.
  longint m_sat  [1024][L];
  longint m_wrap [1024][L];
  int     m_cnt;
  int     m_len;
  bit     ovf_s_exp;
  bit     ovf_w_exp;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_row(input int a, input bit wrap, input bit rl);
    logic [127:0] r = '0;
    for (int k = 0; k < L; k++) begin
      longint v = wrap ? m_wrap[a][k] : m_sat[a][k];
      if (rl && v < 0) v = 0;
      r[k*DS +: DS] = v[DS-1:0];
    end
    return r;
  endfunction

  task automatic model_beat(input bit f, input int d0, input int d1, input int d2, input int d3);
    int     d [L];
    int     a = m_cnt;
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < L; k++) begin
      longint s = (f ? 64'sd0 : m_sat[a][k]) + longint'(d[k]);
      longint w = (f ? 64'sd0 : m_wrap[a][k]) + longint'(d[k]);
      if (s > MAXV) begin s = MAXV; ovf_s_exp = 1'b1; end
      else if (s < MINV) begin s = MINV; ovf_s_exp = 1'b1; end
      if (w > MAXV || w < MINV) begin
        ovf_w_exp = 1'b1;
        w = (((w - MINV) % SPAN) + SPAN) % SPAN + MINV;
      end
      m_sat[a][k]  = s;
      m_wrap[a][k] = w;
    end
    m_cnt = (m_cnt + 1 == m_len) ? 0 : m_cnt + 1;
  endtask

  task automatic drive_beat(input bit f, input int d0, input int d1, input int d2, input int d3);
    first_flag = f;
    dv         = 1'b1;
    din        = {d3[IS-1:0], d2[IS-1:0], d1[IS-1:0], d0[IS-1:0]};
    tick();
    dv         = 1'b0;
    first_flag = 1'b0;
  endtask

  task automatic beat(input bit f, input int d0, input int d1, input int d2, input int d3);
    model_beat(f, d0, d1, d2, d3);
    drive_beat(f, d0, d1, d2, d3);
  endtask

  task automatic start_pass(input int l);
    dven      = 1'b1;
    len       = (AS+1)'(l);
    m_len     = l;
    m_cnt     = 0;
    ovf_s_exp = 1'b0;
    ovf_w_exp = 1'b0;
  endtask

  task automatic finish_pass(input string tag);
    int n = 0;
    dven = 1'b0;
    tick();
    while (busy_s && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 128'(busy_s), 128'(1'b0));
  endtask

  task automatic read_check(input string tag, input int a, input bit rl);
    rd    = 1'b1;
    raddr = AS'(a);
    relu  = rl;
    tick();
    rd = 1'b0;
    tick();
    check({tag, "_rvalid_sat"},  128'(rvalid_s), 128'(1'b1));
    check({tag, "_rdata_sat"},   128'(rdata_s),  exp_row(a, 1'b0, rl));
    check({tag, "_rvalid_wrap"}, 128'(rvalid_w), 128'(1'b1));
    check({tag, "_rdata_wrap"},  128'(rdata_w),  exp_row(a, 1'b1, rl));
    relu = 1'b0;
  endtask

  function automatic int rnd_din();
    return int'($urandom_range(4094, 0)) - 2047;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dven = 1'b0; len = '0; first_flag = 1'b0; dv = 1'b0;
    din = '0; rd = 1'b0; raddr = '0; relu = 1'b0;
    m_cnt = 0; m_len = 1; ovf_s_exp = 1'b0; ovf_w_exp = 1'b0;

    // Reset state
    #12;
    check("rst_rdata",  128'(rdata_s),  128'(0));
    check("rst_rvalid", 128'(rvalid_s), 128'(1'b0));
    check("rst_busy",   128'(busy_s),   128'(1'b0));
    check("rst_ovf",    128'(ovf_s),    128'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();

    // Three passes of 8 beats, readout with and without ReLU
    start_pass(8);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++) beat(p == 0, 1, -2, 3, -4);
    finish_pass("A");
    check("A_ovf", 128'(ovf_s), 128'(ovf_s_exp));
    read_check("A_addr5", 5, 1'b0);
    tick();
    check("A_rvalid_pulse", 128'(rvalid_s), 128'(1'b0));
    read_check("A_addr5_relu", 5, 1'b1);

    // Length 1, back-to-back beats: forwarding from the add stage
    start_pass(1);
    for (int i = 0; i < 5; i++) beat(i == 0, 7, 7, 7, 7);
    finish_pass("B");
    read_check("B_addr0", 0, 1'b0);

    // Length 2 with random beat gaps and random data
    start_pass(2);
    for (int i = 0; i < 16; i++) begin
      beat(i < 2, rnd_din(), rnd_din(), rnd_din(), rnd_din());
      repeat ($urandom_range(3, 0)) tick();
    end
    finish_pass("C");
    read_check("C_addr0", 0, 1'b0);
    read_check("C_addr1", 1, 1'b0);

    // Busy window after dropping I_dven, read requests during busy dropped
    start_pass(4);
    for (int i = 0; i < 4; i++) beat(1'b1, rnd_din(), rnd_din(), rnd_din(), rnd_din());
    dven = 1'b0;
    check("D_busy_t1", 128'(busy_s), 128'(1'b1));
    rd    = 1'b1;
    raddr = AS'(3);
    tick();
    rd = 1'b0;
    check("D_busy_t2", 128'(busy_s), 128'(1'b1));
    tick();
    check("D_busy_t3", 128'(busy_s), 128'(1'b1));
    check("D_rd_dropped", 128'(rvalid_s), 128'(1'b0));
    tick();
    check("D_busy_t4", 128'(busy_s), 128'(1'b0));
    check("D_rd_dropped2", 128'(rvalid_s), 128'(1'b0));
    read_check("D_addr3", 3, 1'b0);

    // Overflow: saturate vs wrap on +2047 past 2^23-1
    start_pass(1);
    for (int i = 0; i < 4200; i++) beat(i == 0, 2047, 2047, 2047, 2047);
    finish_pass("E");
    check("E_ovf_sat",  128'(ovf_s), 128'(ovf_s_exp));
    check("E_ovf_wrap", 128'(ovf_w), 128'(ovf_w_exp));
    read_check("E_addr0", 0, 1'b0);

    // Fresh session clears the sticky flag
    start_pass(4);
    for (int i = 0; i < 4; i++) beat(1'b1, rnd_din(), rnd_din(), rnd_din(), rnd_din());
    finish_pass("F");
    check("F_ovf_sat",  128'(ovf_s), 128'(1'b0));
    check("F_ovf_wrap", 128'(ovf_w), 128'(1'b0));
    read_check("F_addr2", 2, 1'b0);

    // Reset mid-pass: outputs clear, the in-flight beat never lands
    start_pass(4);
    drive_beat(1'b1, 100, 200, 300, 400);
    rst_n = 1'b0;
    dven  = 1'b0;
    #1;
    check("G_rst_rdata",  128'(rdata_s),  128'(0));
    check("G_rst_busy",   128'(busy_s),   128'(1'b0));
    check("G_rst_rvalid", 128'(rvalid_s), 128'(1'b0));
    check("G_rst_ovf",    128'(ovf_s),    128'(1'b0));
    tick();
    check("G_rst_edge_busy",  128'(busy_s),  128'(1'b0));
    check("G_rst_edge_rdata", 128'(rdata_s), 128'(0));
    rst_n = 1'b1;
    tick();
    read_check("G_addr0_kept", 0, 1'b0);
    start_pass(4);
    for (int i = 0; i < 8; i++) beat(i < 4, rnd_din(), rnd_din(), rnd_din(), rnd_din());
    finish_pass("G");
    for (int a = 0; a < 4; a++) read_check("G_fresh", a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
